// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_master
// Brief    : Burst initiator for a single-port synchronous RAM. It takes
//            read/write burst commands and moves beats over valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int                CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  c_RD_LAT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0]   c_LEN_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                w_last_beat;
    logic                w_wait_last;

    assign w_last_beat = (r_remaining == c_LEN_ONE);
    assign w_wait_last = (r_wait_cnt == c_CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr  <= cmd_addr;
                        r_remaining <= cmd_len;
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        r_cur_addr  <= r_cur_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    r_wait_cnt <= c_RD_LAT;
                end
                S_RD_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 1'b1;
                    // ram_q is valid exactly on the final wait cycle
                    if (w_wait_last) begin
                        r_rd_data  <= ram_q;
                        r_rd_valid <= 1'b1;
                    end
                end
                S_RD_OUT: begin
                    if (rd_ready) begin
                        r_rd_valid  <= 1'b0;
                        r_cur_addr  <= r_cur_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0)
                        w_next_state = S_DONE;
                    else if (cmd_write)
                        w_next_state = S_WRITE;
                    else
                        w_next_state = S_RD_ADDR;
                end
            end
            S_WRITE: begin
                if (wr_valid && w_last_beat)
                    w_next_state = S_DONE;
            end
            S_RD_ADDR: w_next_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (w_wait_last)
                    w_next_state = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (rd_ready)
                    w_next_state = w_last_beat ? S_DONE : S_RD_ADDR;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign wr_ready  = (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign ram_we    = (r_state == S_WRITE) && wr_valid && !rst;
    assign ram_addr  = r_cur_addr;
    assign ram_data  = wr_data;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire
